mpeg_audio_ringbuf: RTL

Parametrised, frame-aligned multi-channel PCM sample FIFO between the MPEG audio synthesis output and the audio DAC/mixer path. Stores whole sample frames (all channels of one time instant), holds output back until a programmable prefill level is reached, returns to prefill after an underrun, and reports level, overflow and underrun statistics to the control side. Single clock domain; block RAM storage with a registered, first-word-fall-through output stage.

---
 rtl/mpeg_audio_ringbuf.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mpeg_audio_ringbuf.sv
// Frame-aligned multi-channel PCM FIFO between the MPEG audio synthesis output
// and the DAC/mixer path. Output is held back until a prefill level is reached,
// and the FIFO falls back to prefilling after an underrun. Storage is a block
// RAM whose synchronous read port doubles as the first-word-fall-through
// output register.
module mpeg_audio_ringbuf #(
  parameter int WIDTH      = 16,
  parameter int CHANNELS   = 2,
  parameter int DEPTH_LOG2 = 9,
  parameter int PREFILL    = 70,
  parameter int NF_MARGIN  = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CHANNELS*WIDTH-1:0]   in_frame,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CHANNELS*WIDTH-1:0]   out_frame,
  output logic [DEPTH_LOG2:0]         level,
  output logic                        nearly_full,
  output logic                        prefilled,
  output logic                        underrun,
  output logic                        overflow,
  output logic [15:0]                 underrun_count
);

  localparam int FW    = CHANNELS * WIDTH;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;

  // Level at which writes stop; headroom keeps the RAM from ever being
  // completely full, so pointer equality alone means "RAM empty".
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH - NF_MARGIN);
  localparam logic [LW-1:0] PRE_LVL  = LW'(PREFILL);

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  logic [FW-1:0]         mem [DEPTH];

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  ovld_q, ovld_d;
  logic                  overflow_q, overflow_d;
  logic                  underrun_q, underrun_d;
  logic [15:0]           ucount_q, ucount_d;
  logic [FW-1:0]         out_frame_q;

  logic                  in_ready_c;
  logic                  out_valid_c;
  logic                  push;
  logic                  pop;
  logic                  ram_avail;
  logic                  load;

  // Handshakes, pointer/level bookkeeping and the FILL/RUN decision
  always_comb begin
    in_ready_c  = !reset && !flush && (level_q < FULL_LVL);
    push        = in_valid && in_ready_c;
    out_valid_c = (state_q == S_RUN) && ovld_q;
    pop         = out_valid_c && out_ready;
    ram_avail   = (wr_ptr_q != rd_ptr_q);
    load        = ram_avail && (!ovld_q || pop) && !flush;

    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ovld_d     = ovld_q;
    overflow_d = overflow_q;
    underrun_d = 1'b0;
    ucount_d   = ucount_q;

    if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (load) rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);

    if (load)     ovld_d = 1'b1;
    else if (pop) ovld_d = 1'b0;

    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);

    if (in_valid && !in_ready_c && !reset && !flush) overflow_d = 1'b1;

    case (state_q)
      S_FILL: if (level_q >= PRE_LVL) state_d = S_RUN;
      S_RUN: begin
        // A frame still in RAM read latency keeps level above zero, so it
        // never counts as an underrun.
        if (out_ready && (level_q == '0)) begin
          state_d    = S_FILL;
          underrun_d = 1'b1;
          if (ucount_q != 16'hFFFF) ucount_d = ucount_q + 16'd1;
        end
      end
      default: state_d = S_FILL;
    endcase

    if (flush) begin
      state_d    = S_FILL;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      ovld_d     = 1'b0;
      underrun_d = 1'b0;
      ucount_d   = ucount_q;
    end
  end

  // Control state registers; reset also clears the statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FILL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovld_q     <= 1'b0;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
      ucount_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovld_q     <= ovld_d;
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
      ucount_q   <= ucount_d;
    end
  end

  // Frame storage write port; never bypassed to the output
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_frame;
  end

  // Synchronous RAM read straight into the output frame register
  always_ff @(posedge clk) begin
    if (reset)     out_frame_q <= '0;
    else if (load) out_frame_q <= mem[rd_ptr_q];
  end

  assign in_ready       = in_ready_c;
  assign out_valid      = out_valid_c;
  assign out_frame      = out_frame_q;
  assign level          = level_q;
  assign nearly_full    = (level_q >= FULL_LVL);
  assign prefilled      = (level_q >= PRE_LVL);
  assign underrun       = underrun_q;
  assign overflow       = overflow_q;
  assign underrun_count = ucount_q;

endmodule
